// File: rtl/irq_sequencer.sv
// Post-instruction sequencer: soft reset, NMI, BRK/IRQ entry and RTI return.
// Drives the shared memory bus while busy and returns PC/P/SP with a done pulse.
module irq_sequencer #(
  parameter logic [15:0] NMI_VEC = 16'hFFFA,
  parameter logic [15:0] RST_VEC = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        write_en,
  input  logic        is_break,
  input  logic [7:0]  ppu_status,
  input  logic        soft_reset,
  input  logic        is_rti,
  input  logic        start,
  output logic        done,
  output logic        busy,
  input  logic [15:0] pc_in,
  input  logic [7:0]  status_in,
  input  logic [7:0]  stack_in,
  output logic [15:0] pc_out,
  output logic [7:0]  status_out,
  output logic [7:0]  stack_out,
  output logic        interrupt_disable,
  input  logic        halt,
  input  logic        nIRQ
);

  typedef enum logic [1:0] {StIdle, StPush, StRead, StDone} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_w_q, pc_w_d;
  logic [7:0]  st_w_q, st_w_d;
  logic [7:0]  sp_w_q, sp_w_d;
  logic [7:0]  push_p_q, push_p_d;
  logic [15:0] vec_q, vec_d;
  logic        pull_q, pull_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [7:0]  status_out_q, status_out_d;
  logic [7:0]  stack_out_q, stack_out_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        rst_pend_q, rst_pend_d;
  logic        ppu7_q;
  logic        nmi_take, rst_take;
  logic        do_push;
  logic [15:0] push_vec;
  logic [7:0]  push_val;
  logic        unused_ppu;

  assign unused_ppu = ^ppu_status[6:0];

  always_comb begin
    state_d      = state_q;
    pc_w_d       = pc_w_q;
    st_w_d       = st_w_q;
    sp_w_d       = sp_w_q;
    push_p_d     = push_p_q;
    vec_d        = vec_q;
    pull_d       = pull_q;
    step_d       = step_q;
    addr_d       = addr_q;
    data_out_d   = data_out_q;
    we_d         = we_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pc_out_d     = pc_out_q;
    status_out_d = status_out_q;
    stack_out_d  = stack_out_q;
    nmi_take     = 1'b0;
    rst_take     = 1'b0;
    do_push      = 1'b0;
    push_vec     = IRQ_VEC;
    push_val     = 8'h00;

    if (!halt) begin
      done_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_d = 1'b1;
            pc_w_d = pc_in;
            st_w_d = status_in;
            sp_w_d = stack_in;
            step_d = 2'd0;
            if (rst_pend_q) begin
              rst_take = 1'b1;
              sp_w_d   = stack_in - 8'd3;
              st_w_d   = status_in | 8'h04;
              vec_d    = RST_VEC;
              addr_d   = RST_VEC;
              pull_d   = 1'b0;
              state_d  = StRead;
            end else if (nmi_pend_q) begin
              nmi_take = 1'b1;
              do_push  = 1'b1;
              push_vec = NMI_VEC;
              push_val = (status_in | 8'h20) & 8'hEF;
            end else if (is_break) begin
              do_push  = 1'b1;
              push_val = status_in | 8'h30;
            end else if (is_rti) begin
              sp_w_d  = stack_in + 8'd1;
              addr_d  = {8'h01, stack_in + 8'd1};
              pull_d  = 1'b1;
              state_d = StRead;
            end else if (!nIRQ && !status_in[2]) begin
              do_push  = 1'b1;
              push_val = (status_in | 8'h20) & 8'hEF;
            end else begin
              state_d = StDone;
            end
          end
        end
        StPush: begin
          sp_w_d = sp_w_q - 8'd1;
          step_d = step_q + 2'd1;
          if (step_q == 2'd0) begin
            addr_d     = {8'h01, sp_w_q - 8'd1};
            data_out_d = pc_w_q[7:0];
          end else if (step_q == 2'd1) begin
            addr_d     = {8'h01, sp_w_q - 8'd1};
            data_out_d = push_p_q;
          end else begin
            we_d    = 1'b0;
            addr_d  = vec_q;
            pull_d  = 1'b0;
            step_d  = 2'd0;
            state_d = StRead;
          end
        end
        StRead: begin
          // Reads are pipelined: read n is captured two steps after it is issued.
          step_d = step_q + 2'd1;
          if (pull_q) begin
            if (step_q < 2'd2) begin
              sp_w_d = sp_w_q + 8'd1;
              addr_d = {8'h01, sp_w_q + 8'd1};
            end
            if (step_q == 2'd1) st_w_d = {data_in[7:6], 2'b00, data_in[3:0]};
            if (step_q == 2'd2) pc_w_d[7:0] = data_in;
            if (step_q == 2'd3) begin
              pc_w_d[15:8] = data_in;
              state_d      = StDone;
            end
          end else begin
            if (step_q == 2'd0) addr_d = vec_q + 16'd1;
            if (step_q == 2'd1) pc_w_d[7:0] = data_in;
            if (step_q == 2'd2) begin
              pc_w_d[15:8] = data_in;
              state_d      = StDone;
            end
          end
        end
        StDone: begin
          pc_out_d     = pc_w_q;
          status_out_d = st_w_q;
          stack_out_d  = sp_w_q;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          we_d         = 1'b0;
          state_d      = StIdle;
        end
        default: state_d = StIdle;
      endcase

      if (do_push) begin
        st_w_d     = status_in | 8'h04;
        push_p_d   = push_val;
        vec_d      = push_vec;
        addr_d     = {8'h01, stack_in};
        data_out_d = pc_in[15:8];
        we_d       = 1'b1;
        state_d    = StPush;
      end
    end

    nmi_pend_d = (ppu_status[7] & ~ppu7_q) | (nmi_pend_q & ~nmi_take);
    rst_pend_d = soft_reset | (rst_pend_q & ~rst_take);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      pc_w_q       <= 16'h0000;
      st_w_q       <= 8'h00;
      sp_w_q       <= 8'hFF;
      push_p_q     <= 8'h00;
      vec_q        <= 16'h0000;
      pull_q       <= 1'b0;
      step_q       <= 2'd0;
      addr_q       <= 16'h0000;
      data_out_q   <= 8'h00;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pc_out_q     <= 16'h0000;
      status_out_q <= 8'h00;
      stack_out_q  <= 8'hFF;
      nmi_pend_q   <= 1'b0;
      rst_pend_q   <= 1'b0;
      ppu7_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_w_q       <= pc_w_d;
      st_w_q       <= st_w_d;
      sp_w_q       <= sp_w_d;
      push_p_q     <= push_p_d;
      vec_q        <= vec_d;
      pull_q       <= pull_d;
      step_q       <= step_d;
      addr_q       <= addr_d;
      data_out_q   <= data_out_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pc_out_q     <= pc_out_d;
      status_out_q <= status_out_d;
      stack_out_q  <= stack_out_d;
      nmi_pend_q   <= nmi_pend_d;
      rst_pend_q   <= rst_pend_d;
      ppu7_q       <= ppu_status[7];
    end
  end

  assign addr              = addr_q;
  assign data_out          = data_out_q;
  assign write_en          = we_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign pc_out            = pc_out_q;
  assign status_out        = status_out_q;
  assign stack_out         = stack_out_q;
  assign interrupt_disable = status_out_q[2];

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed cases plus random transactions scored against
// a transaction-level model of the priority rules, stack layout and latency.
module tb_irq_sequencer;

  localparam logic [15:0] NMI_V = 16'hFFFA;
  localparam logic [15:0] RST_V = 16'hFFFC;
  localparam logic [15:0] IRQ_V = 16'hFFFE;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        write_en;
  logic        is_break, soft_reset, is_rti, start, halt, nIRQ;
  logic [7:0]  ppu_status;
  logic        done, busy, interrupt_disable;
  logic [15:0] pc_in, pc_out;
  logic [7:0]  status_in, stack_in, status_out, stack_out;

  always #5 clk = ~clk;

  irq_sequencer dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(data_out),
    .write_en(write_en), .is_break(is_break), .ppu_status(ppu_status),
    .soft_reset(soft_reset), .is_rti(is_rti), .start(start), .done(done), .busy(busy),
    .pc_in(pc_in), .status_in(status_in), .stack_in(stack_in), .pc_out(pc_out),
    .status_out(status_out), .stack_out(stack_out),
    .interrupt_disable(interrupt_disable), .halt(halt), .nIRQ(nIRQ)
  );

  // Memory with two-edge read latency, a bench poke port and a write log
  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        pk_en = 1'b0;
  logic [15:0] pk_addr = 16'h0;
  logic [7:0]  pk_data = 8'h0;
  logic [15:0] wr_a [0:1023];
  logic [7:0]  wr_d [0:1023];
  logic [9:0]  wr_cnt = 10'd0;
  logic        prev_we = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [7:0]  prev_data = 8'h0;

  always @(posedge clk) begin
    if (pk_en) mem[pk_addr] <= pk_data;
    else if (write_en) mem[addr] <= data_out;
    data_in <= mem[addr];
    if (write_en && !(prev_we && prev_addr == addr && prev_data == data_out)) begin
      wr_a[wr_cnt] <= addr;
      wr_d[wr_cnt] <= data_out;
      wr_cnt <= wr_cnt + 10'd1;
    end
    prev_we   <= write_en;
    prev_addr <= addr;
    prev_data <= data_out;
  end

  int checks = 0;
  int failures = 0;
  bit m_nmi = 1'b0;
  bit m_rst = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pk_en = 1'b1; pk_addr = a; pk_data = d; ref_mem[a] = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic nmi_event();
    ppu_status = {1'b1, 7'($urandom)};
    @(negedge clk);
    ppu_status[7] = 1'b0;
    @(negedge clk);
    m_nmi = 1'b1;
  endtask

  task automatic srst_event();
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    @(negedge clk);
    m_rst = 1'b1;
  endtask

  // Model: pick the action by priority, derive outputs, writes and latency
  task automatic run_txn(input logic [15:0] pc, input logic [7:0] st, input logic [7:0] sp,
                         input logic brk, input logic rti, input logic nirq,
                         input bit rnd_mem, input int hold, input bit extra);
    int act, nw, lat, cycles;
    logic [15:0] vec, e_pc, ha;
    logic [7:0] pushp, e_st, e_sp;
    logic [15:0] ea [3];
    logic [7:0] ed [3];
    logic [9:0] w0;
    bit busy_ok, hw;
    vec = IRQ_V; pushp = 8'h00; nw = 0; lat = 1;
    if (m_rst) begin act = 1; vec = RST_V; end
    else if (m_nmi) begin act = 2; vec = NMI_V; pushp = (st | 8'h20) & 8'hEF; end
    else if (brk) begin act = 2; pushp = st | 8'h30; end
    else if (rti) act = 3;
    else if (!nirq && !st[2]) begin act = 2; pushp = (st | 8'h20) & 8'hEF; end
    else act = 0;
    if (rnd_mem) begin
      if (act == 1 || act == 2) begin
        poke(vec, 8'($urandom));
        poke(vec + 16'd1, 8'($urandom));
      end
      if (act == 3) for (int k = 1; k <= 3; k++) poke({8'h01, 8'(sp + 8'(k))}, 8'($urandom));
    end
    e_pc = pc; e_st = st; e_sp = sp;
    case (act)
      1: begin
        e_sp = sp - 8'd3; e_st = st | 8'h04; e_pc = {ref_mem[vec + 16'd1], ref_mem[vec]};
        lat = 4; m_rst = 1'b0;
      end
      2: begin
        ea[0] = {8'h01, sp};          ed[0] = pc[15:8];
        ea[1] = {8'h01, sp - 8'd1};   ed[1] = pc[7:0];
        ea[2] = {8'h01, sp - 8'd2};   ed[2] = pushp;
        nw = 3; e_sp = sp - 8'd3; e_st = st | 8'h04;
        e_pc = {ref_mem[vec + 16'd1], ref_mem[vec]}; lat = 7;
        if (vec == NMI_V) m_nmi = 1'b0;
      end
      3: begin
        e_st = ref_mem[{8'h01, sp + 8'd1}] & 8'hCF;
        e_pc = {ref_mem[{8'h01, sp + 8'd3}], ref_mem[{8'h01, sp + 8'd2}]};
        e_sp = sp + 8'd3; lat = 5;
      end
      default: lat = 1;
    endcase

    w0 = wr_cnt;
    pc_in = pc; status_in = st; stack_in = sp;
    is_break = brk; is_rti = rti; nIRQ = nirq; start = 1'b1;
    cycles = 0; busy_ok = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (!done) begin
        if (!busy) busy_ok = 1'b0;
        if (extra && cycles == 1) start = 1'b1;
        if (hold > 0 && cycles == 2) begin
          hw = write_en; ha = addr; halt = 1'b1;
          if (act == 2) check_eq("halt_at", 32'(ha), 32'({8'h01, sp - 8'd1}));
          for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            cycles++;
            check_eq("halt_we", 32'(write_en), 32'(hw));
            check_eq("halt_addr", 32'(addr), 32'(ha));
          end
          halt = 1'b0;
        end
      end
    end while (!done && cycles < 60);

    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("latency", 32'(cycles), 32'(lat + 1 + hold));
    check_eq("busy_during", 32'(busy_ok), 32'd1);
    check_eq("busy_at_done", 32'(busy), 32'd0);
    check_eq("we_at_done", 32'(write_en), 32'd0);
    check_eq("pc_out", 32'(pc_out), 32'(e_pc));
    check_eq("status_out", 32'(status_out), 32'(e_st));
    check_eq("stack_out", 32'(stack_out), 32'(e_sp));
    check_eq("int_dis", 32'(interrupt_disable), 32'(e_st[2]));
    check_eq("write_count", 32'(10'(wr_cnt - w0)), 32'(nw));
    for (int i = 0; i < nw; i++) begin
      check_eq("write_addr", 32'(wr_a[10'(w0 + 10'(i))]), 32'(ea[i]));
      check_eq("write_data", 32'(wr_d[10'(w0 + 10'(i))]), 32'(ed[i]));
    end
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
    is_break = 1'b0; is_rti = 1'b0; nIRQ = 1'b1;
  endtask

  initial begin
    logic [9:0] w;
    rst = 1'b0; is_break = 1'b0; soft_reset = 1'b0; is_rti = 1'b0; start = 1'b0;
    halt = 1'b0; nIRQ = 1'b1; ppu_status = 8'h00;
    pc_in = 16'h0; status_in = 8'h0; stack_in = 8'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_addr", 32'(addr), 32'd0);
    check_eq("rst_we", 32'(write_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_dout", 32'(data_out), 32'd0);
    check_eq("rst_pc", 32'(pc_out), 32'd0);
    check_eq("rst_st", 32'(status_out), 32'd0);
    check_eq("rst_sp", 32'(stack_out), 32'hFF);
    check_eq("rst_idis", 32'(interrupt_disable), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_txn(16'h8003, 8'h24, 8'hFD, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    check_eq("none_pc", 32'(pc_out), 32'h8003);

    poke(16'hFFFE, 8'h34); poke(16'hFFFF, 8'h12);
    run_txn(16'hC102, 8'h00, 8'hFD, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    check_eq("brk_pc", 32'(pc_out), 32'h1234);
    check_eq("brk_sp", 32'(stack_out), 32'hFA);

    nmi_event();
    poke(16'hFFFA, 8'h00); poke(16'hFFFB, 8'h80);
    run_txn(16'h9000, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    check_eq("nmi_pc", 32'(pc_out), 32'h8000);
    check_eq("nmi_st", 32'(status_out), 32'h05);

    poke(16'h01FB, 8'hF3); poke(16'h01FC, 8'h02); poke(16'h01FD, 8'hC1);
    run_txn(16'h4000, 8'h00, 8'hFA, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("rti_pc", 32'(pc_out), 32'hC102);
    check_eq("rti_st", 32'(status_out), 32'hC3);

    run_txn(16'h5000, 8'h04, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    check_eq("irq_masked_pc", 32'(pc_out), 32'h5000);
    run_txn(16'h5000, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    check_eq("irq_pc", 32'(pc_out), 32'h1234);
    check_eq("irq_sp_wrap", 32'(stack_out), 32'hFE);

    srst_event();
    poke(16'hFFFC, 8'h00); poke(16'hFFFD, 8'hC0);
    run_txn(16'h8100, 8'h00, 8'hFD, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    check_eq("srst_pc", 32'(pc_out), 32'hC000);
    check_eq("srst_sp", 32'(stack_out), 32'hFA);

    run_txn(16'hC102, 8'h00, 8'hFD, 1'b1, 1'b0, 1'b1, 1'b0, 5, 1'b0);
    check_eq("halt_brk_pc", 32'(pc_out), 32'h1234);

    // Reset in the middle of a push sequence
    pc_in = 16'hABCD; status_in = 8'h00; stack_in = 8'hE0; is_break = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    w = wr_cnt;
    check_eq("abort_we", 32'(write_en), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_sp", 32'(stack_out), 32'hFF);
    @(negedge clk);
    rst = 1'b1; is_break = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("abort_no_writes", 32'(wr_cnt), 32'(w));
    check_eq("abort_idle_busy", 32'(busy), 32'd0);
    m_nmi = 1'b0; m_rst = 1'b0;

    for (int t = 0; t < 120; t++) begin
      logic brk, rti;
      brk = ($urandom % 5) == 0;
      rti = !brk && (($urandom % 4) == 0);
      if (($urandom % 5) == 0) nmi_event();
      if (($urandom % 7) == 0) srst_event();
      run_txn(16'($urandom), 8'($urandom), 8'($urandom), brk, rti,
              1'(($urandom % 3) != 0), 1'b1, 0, 1'(($urandom % 4) == 0));
      repeat ($urandom % 3) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
